// File: rtl/int8_8x8_b_transposer.sv
// Ping-pong 8x8 int8 transposer: row-major rows in, column-major columns out.
// Define TRANSPOSER_TLAST_EN to add s_tlast/m_tlast framing and a sticky err flag.
module int8_8x8_b_transposer #(
  parameter int N  = 8,
  parameter int EW = 8
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic [N*EW-1:0] s_tdata,
  input  logic            s_tvalid,
  output logic            s_tready,
`ifdef TRANSPOSER_TLAST_EN
  input  logic            s_tlast,
  output logic            m_tlast,
  output logic            err,
`endif
  output logic [N*EW-1:0] m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            idle
);

  localparam int W = N * EW;

  generate
    if (N != 8) begin : g_bad_n
      $error("int8_8x8_b_transposer: N must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'b00,
    BANK_FULL  = 2'b01
  } bank_state_t;

  bank_state_t bank_state_r [2];
  logic [W-1:0] mem_r [2][N];
  logic         wr_bank_r;
  logic         rd_bank_r;
  logic [2:0]   wr_row_r;
  logic [2:0]   rd_col_r;

  logic [W-1:0] col_s;
  logic         wr_fire_s;
  logic         wr_close_s;
  logic         rd_load_s;
  logic         rd_done_s;
  logic [1:0]   set_full_s;
  logic [1:0]   set_empty_s;

  assign s_tready  = (bank_state_r[wr_bank_r] == BANK_EMPTY);
  assign wr_fire_s = s_tvalid & s_tready;
`ifdef TRANSPOSER_TLAST_EN
  assign wr_close_s = (wr_row_r == 3'd7) | s_tlast;
`else
  assign wr_close_s = (wr_row_r == 3'd7);
`endif
  assign rd_load_s = (bank_state_r[rd_bank_r] == BANK_FULL) & (~m_tvalid | m_tready);
  assign rd_done_s = rd_load_s & (rd_col_r == 3'd7);
  assign idle      = (bank_state_r[0] == BANK_EMPTY) & (bank_state_r[1] == BANK_EMPTY) & ~m_tvalid;

  // Column rd_col of the draining bank: byte r comes from row r.
  always_comb begin
    col_s = '0;
    for (int r = 0; r < N; r++) begin
      col_s[r*EW +: EW] = mem_r[rd_bank_r][r][int'(rd_col_r)*EW +: EW];
    end
  end

  // Per-bank state transitions; write-close and read-close always target different banks.
  always_comb begin
    set_full_s  = 2'b00;
    set_empty_s = 2'b00;
    if (wr_fire_s && wr_close_s) begin
      set_full_s[wr_bank_r] = 1'b1;
    end else begin
      set_full_s = 2'b00;
    end
    if (rd_done_s) begin
      set_empty_s[rd_bank_r] = 1'b1;
    end else begin
      set_empty_s = 2'b00;
    end
  end

  // Row storage; an early frame close zero-fills the rows that were never written.
  always_ff @(posedge ap_clk) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][wr_row_r] <= s_tdata;
`ifdef TRANSPOSER_TLAST_EN
      if (s_tlast && (wr_row_r != 3'd7)) begin
        for (int r = 0; r < N; r++) begin
          if (r > int'(wr_row_r)) begin
            mem_r[wr_bank_r][r] <= '0;
          end
        end
      end
`endif
    end
  end

  // Pointers, bank states and the registered output stage.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_bank_r       <= 1'b0;
      rd_bank_r       <= 1'b0;
      wr_row_r        <= 3'd0;
      rd_col_r        <= 3'd0;
      bank_state_r[0] <= BANK_EMPTY;
      bank_state_r[1] <= BANK_EMPTY;
      m_tdata         <= '0;
      m_tvalid        <= 1'b0;
`ifdef TRANSPOSER_TLAST_EN
      m_tlast         <= 1'b0;
      err             <= 1'b0;
`endif
    end else begin
      if (wr_fire_s) begin
        if (wr_close_s) begin
          wr_row_r  <= 3'd0;
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_row_r <= wr_row_r + 3'd1;
        end
      end

      for (int b = 0; b < 2; b++) begin
        if (set_full_s[b]) begin
          bank_state_r[b] <= BANK_FULL;
        end else if (set_empty_s[b]) begin
          bank_state_r[b] <= BANK_EMPTY;
        end
      end

      if (rd_load_s) begin
        m_tdata  <= col_s;
        m_tvalid <= 1'b1;
        rd_col_r <= rd_col_r + 3'd1;
`ifdef TRANSPOSER_TLAST_EN
        m_tlast  <= (rd_col_r == 3'd7);
`endif
        if (rd_col_r == 3'd7) begin
          rd_bank_r <= ~rd_bank_r;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

`ifdef TRANSPOSER_TLAST_EN
      if (wr_fire_s && (s_tlast != (wr_row_r == 3'd7))) begin
        err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_int8_8x8_b_transposer.sv
// Randomized scoreboard bench for int8_8x8_b_transposer (transpose model built from accepted rows).
module tb_int8_8x8_b_transposer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = 64'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        idle;
`ifdef TRANSPOSER_TLAST_EN
  logic        s_tlast = 1'b0;
  logic        m_tlast;
  logic        err;
`endif

  int total = 0;
  int bad = 0;

  logic [63:0] src_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  bit          got_last_q[$];
  logic [63:0] acc[8];
  int          acc_n = 0;

  int8_8x8_b_transposer dut (
    .ap_clk(clk),
    .ap_rst_n(rst_n),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
`ifdef TRANSPOSER_TLAST_EN
    .s_tlast(s_tlast),
    .m_tlast(m_tlast),
    .err(err),
`endif
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference: matrix of accepted rows -> 8 columns, column j byte r = row r byte j.
  task automatic push_matrix();
    logic [63:0] col;
    for (int j = 0; j < 8; j++) begin
      col = 64'd0;
      for (int r = 0; r < 8; r++) col[8*r +: 8] = acc[r][8*j +: 8];
      exp_q.push_back(col);
    end
    for (int r = 0; r < 8; r++) acc[r] = 64'd0;
    acc_n = 0;
  endtask

  task automatic drive_src(int vpct);
    s_tvalid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
    s_tdata  = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom};
`ifdef TRANSPOSER_TLAST_EN
    s_tlast  = (acc_n == 7);
`endif
  endtask

  task automatic tick();
    bit in_fire, out_fire, sl, ml;
    logic [63:0] sd, md;
    in_fire  = s_tvalid && s_tready;
    out_fire = m_tvalid && m_tready;
    sd = s_tdata;
    md = m_tdata;
    sl = 1'b0;
    ml = 1'b0;
`ifdef TRANSPOSER_TLAST_EN
    sl = s_tlast;
    ml = m_tlast;
`endif
    @(posedge clk);
    #1;
    if (in_fire) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      acc[acc_n] = sd;
      acc_n++;
      if (acc_n == 8 || sl) push_matrix();
    end
    if (out_fire) begin
      got_q.push_back(md);
      got_last_q.push_back(ml);
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
`ifdef TRANSPOSER_TLAST_EN
    s_tlast = 1'b0;
`endif
    rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    got_last_q.delete();
    for (int r = 0; r < 8; r++) acc[r] = 64'd0;
    acc_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tdata !== 64'd0) begin bad++; $display("FAIL reset_m_tdata got=%h want=0", m_tdata); end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_s_tready got=%b want=1", s_tready); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
  endtask

  task automatic test_single();
    logic [63:0] row, want;
    do_reset();
    m_tready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[8*c +: 8] = 8'(8*r + c);
      src_q.push_back(row);
    end
    repeat (8) begin drive_src(100); tick(); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%b want=0", m_tvalid); end
    drive_src(100);
    tick();
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", m_tvalid); end
    total++; if (m_tdata !== 64'h3830282018100800) begin bad++; $display("FAIL single_col0 got=%h want=3830282018100800", m_tdata); end
    repeat (8) begin drive_src(100); tick(); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL single_beats got=%0d want=8", got_q.size()); end
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      for (int r = 0; r < 8; r++) want[8*r +: 8] = 8'(8*r + j);
      total++; if (got_q[j] !== want) begin bad++; $display("FAIL single_col%0d got=%h want=%h", j, got_q[j], want); end
    end
  endtask

  task automatic test_back_to_back();
    int drops, gaps;
    bit started;
    do_reset();
    m_tready = 1'b1;
    drops = 0; gaps = 0; started = 1'b0;
    repeat (32) src_q.push_back({$urandom, $urandom});
    for (int cyc = 0; cyc < 60; cyc++) begin
      drive_src(100);
      if (src_q.size() > 0 && s_tready !== 1'b1) drops++;
      tick();
      if (m_tvalid) started = 1'b1;
      else if (started && got_q.size() < 32) gaps++;
    end
    total++; if (drops != 0) begin bad++; $display("FAIL b2b_s_tready_drops got=%0d want=0", drops); end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    total++; if (got_q.size() != 32) begin bad++; $display("FAIL b2b_beats got=%0d want=32", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int unstable;
    do_reset();
    unstable = 0;
    repeat (16) src_q.push_back({$urandom, $urandom});
    repeat (9) begin drive_src(100); tick(); end
    total++; if (m_tvalid !== 1'b1 || exp_q.size() == 0) begin bad++; $display("FAIL bp_valid got=%b want=1", m_tvalid); end
    else begin
      total++; if (m_tdata !== exp_q[0]) begin bad++; $display("FAIL bp_col0 got=%h want=%h", m_tdata, exp_q[0]); end
    end
    held = m_tdata;
    repeat (20) begin
      drive_src(100);
      tick();
      if (m_tdata !== held || m_tvalid !== 1'b1) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold got=%0d changes want=0", unstable); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL bp_s_tready got=%b want=0", s_tready); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", idle); end
    m_tready = 1'b1;
    repeat (30) begin drive_src(100); tick(); end
    total++; if (got_q.size() != 16) begin bad++; $display("FAIL bp_beats got=%0d want=16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cyc, errs;
    do_reset();
    repeat (800) src_q.push_back({$urandom, $urandom});
    cyc = 0;
    while (got_q.size() < 800 && cyc < 20000) begin
      drive_src(50);
      m_tready = 1'($urandom_range(1));
      tick();
      cyc++;
    end
    total++; if (cyc >= 20000) begin bad++; $display("FAIL rand_timeout got=%0d beats want=800", got_q.size()); end
    m_tready = 1'b1;
    repeat (12) begin drive_src(50); tick(); end
    total++; if (got_q.size() != 800) begin bad++; $display("FAIL rand_beats got=%0d want=800", got_q.size()); end
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        errs++;
        if (errs <= 5) $display("rand beat %0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rand_data got=%0d wrong beats want=0", errs); end
`ifdef TRANSPOSER_TLAST_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rand_err got=%b want=0", err); end
`endif
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    repeat (13) src_q.push_back({$urandom, $urandom});
    cyc = 0;
    while (!(src_q.size() == 0 && got_q.size() == 3) && cyc < 100) begin
      m_tready = (got_q.size() < 3);
      drive_src(100);
      tick();
      cyc++;
    end
    total++; if (cyc >= 100) begin bad++; $display("FAIL mid_setup got=%0d beats want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_pre_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    rst_n = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_m_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tdata !== 64'd0) begin bad++; $display("FAIL mid_rst_m_tdata got=%h want=0", m_tdata); end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL mid_rst_s_tready got=%b want=1", s_tready); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_rst_idle got=%b want=1", idle); end
    do_reset();
    m_tready = 1'b1;
    repeat (8) src_q.push_back({$urandom, $urandom});
    repeat (20) begin drive_src(100); tick(); end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL mid_post_beats got=%0d want=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_post_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef TRANSPOSER_TLAST_EN
  task automatic test_tlast();
    do_reset();
    m_tready = 1'b1;
    repeat (5) src_q.push_back({$urandom, $urandom});
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0];
      s_tlast  = (i == 4);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tlast_err got=%b want=1", err); end
    repeat (12) tick();
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL tlast_beats got=%0d want=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i] || got_q[i][63:40] !== 24'd0) begin bad++; $display("FAIL tlast_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      total++; if (got_last_q[i] !== (i == 7)) begin bad++; $display("FAIL tlast_m_tlast%0d got=%b want=%b", i, got_last_q[i], (i == 7)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef TRANSPOSER_TLAST_EN
    test_tlast();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
